// File: rtl/gpio_pkg.sv
// Shared GPIO types and helpers for the input-conditioning path.
// Vector width default and prescaler counter sizing.
package gpio_pkg;

    localparam int GPIO_SIZE_DEFAULT = 32;

    typedef logic [GPIO_SIZE_DEFAULT-1:0] gpio_vec_t;

    function automatic int tick_cnt_width(input int div);
        return $clog2(div);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO bit: two-flop synchroniser, optional tick-based debounce, level flop and raw edges.
// Pad-to-level is 3 edges in bypass; no backpressure, edges are single-cycle pulses.
module gpio_debounce_bit #(
    parameter int DEB_TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    input  logic i_tick,
    input  logic i_deb_en,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int             CW       = $clog2(DEB_TICKS + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_TICKS - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_level_next;
    logic [CW-1:0] w_cnt_next;

    // The level only flips after DEB_TICKS consecutive ticks of disagreement.
    always_comb begin
        w_level_next = r_level;
        w_cnt_next   = r_cnt;
        if (!i_deb_en) begin
            w_level_next = r_sync2;
            w_cnt_next   = '0;
        end else if (r_sync2 == r_level) begin
            w_cnt_next = '0;
        end else if (i_tick) begin
            if (r_cnt == CNT_LAST) begin
                w_level_next = r_sync2;
                w_cnt_next   = '0;
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_level <= w_level_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign o_level = r_level;
    assign o_rise  = ~r_level & w_level_next;
    assign o_fall  = r_level & ~w_level_next;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Conditions raw GPIO pads into levels, latches enabled edges as sticky pending bits, ORs them to irq_o.
// Pending sets in the same edge the level changes; no backpressure, clear is a write-1 pulse.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int SIZE      = GPIO_SIZE_DEFAULT,
    parameter int TICK_DIV  = 1000,
    parameter int DEB_TICKS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] pin_i,
    input  logic [SIZE-1:0] dir_i,
    input  logic            deb_en_i,
    input  logic [SIZE-1:0] rise_en_i,
    input  logic [SIZE-1:0] fall_en_i,
    input  logic [SIZE-1:0] clr_i,
    output logic [SIZE-1:0] level_o,
    output logic [SIZE-1:0] pending_o,
    output logic            irq_o
);

    // A divide of 1 still needs a one-bit counter that simply stays at zero.
    localparam int TW = (tick_cnt_width(TICK_DIV) < 1) ? 1 : tick_cnt_width(TICK_DIV);

    logic [TW-1:0]   r_presc;
    logic            w_tick;
    logic [SIZE-1:0] w_level;
    logic [SIZE-1:0] w_rise;
    logic [SIZE-1:0] w_fall;
    logic [SIZE-1:0] w_set;
    logic [SIZE-1:0] r_pending;

    assign w_tick = (r_presc == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + TW'(1);
        end
    end

    for (genvar g = 0; g < SIZE; g++) begin : g_bit
        gpio_debounce_bit #(
            .DEB_TICKS (DEB_TICKS)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .i_pin    (pin_i[g]),
            .i_tick   (w_tick),
            .i_deb_en (deb_en_i),
            .o_level  (w_level[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
    end

    assign w_set = ((w_rise & rise_en_i) | (w_fall & fall_en_i)) & ~dir_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~clr_i) | w_set;
        end
    end

    assign level_o   = w_level & ~dir_i;
    assign pending_o = r_pending;
    assign irq_o     = |r_pending;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with TICK_DIV=4, DEB_TICKS=3.
module tb_gpio_input_conditioner;
    import gpio_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    gpio_vec_t pin_i;
    gpio_vec_t dir_i;
    logic      deb_en_i;
    gpio_vec_t rise_en_i;
    gpio_vec_t fall_en_i;
    gpio_vec_t clr_i;
    gpio_vec_t level_o;
    gpio_vec_t pending_o;
    logic      irq_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gpio_input_conditioner #(
        .SIZE      (32),
        .TICK_DIV  (4),
        .DEB_TICKS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pin_i     (pin_i),
        .dir_i     (dir_i),
        .deb_en_i  (deb_en_i),
        .rise_en_i (rise_en_i),
        .fall_en_i (fall_en_i),
        .clr_i     (clr_i),
        .level_o   (level_o),
        .pending_o (pending_o),
        .irq_o     (irq_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic seen_lvl;
    logic seen_pnd;
    int   first;

    initial begin
        rst       = 1'b1;
        pin_i     = '0;
        dir_i     = '0;
        deb_en_i  = 1'b0;
        rise_en_i = '0;
        fall_en_i = '0;
        clr_i     = '0;

        step(2);
        check_eq("rst_level", level_o, 32'h0);
        check_eq("rst_pending", pending_o, 32'h0);
        check_eq("rst_irq", irq_o, 1'b0);
        rst = 1'b0;
        step(2);

        // Bypass: 3-edge latency and write-1-to-clear.
        rise_en_i[3] = 1'b1;
        pin_i[3]     = 1'b1;
        step(2);
        check_eq("byp_lvl_edge2", level_o[3], 1'b0);
        step(1);
        check_eq("byp_lvl_edge3", level_o[3], 1'b1);
        check_eq("byp_pnd_edge3", pending_o[3], 1'b1);
        check_eq("byp_irq_set", irq_o, 1'b1);
        clr_i[3] = 1'b1;
        step(1);
        clr_i[3] = 1'b0;
        check_eq("byp_pnd_clr", pending_o[3], 1'b0);
        check_eq("byp_irq_clr", irq_o, 1'b0);

        // Direction mask hides level and edges on an output bit.
        dir_i[7]     = 1'b1;
        rise_en_i[7] = 1'b1;
        fall_en_i[7] = 1'b1;
        seen_lvl     = 1'b0;
        seen_pnd     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pin_i[7] = ~pin_i[7];
            step(2);
            seen_lvl |= level_o[7];
            seen_pnd |= pending_o[7];
        end
        pin_i[7] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            seen_lvl |= level_o[7];
            seen_pnd |= pending_o[7];
        end
        check_eq("dir_lvl_masked", seen_lvl, 1'b0);
        check_eq("dir_pnd_masked", seen_pnd, 1'b0);
        dir_i[7] = 1'b0;
        #1;
        check_eq("dir_expose_lvl", level_o[7], 1'b1);
        step(1);
        check_eq("dir_expose_nopnd", pending_o[7], 1'b0);

        // Set wins over a clear in the same cycle.
        rise_en_i[5] = 1'b1;
        fall_en_i[5] = 1'b1;
        pin_i[5]     = 1'b1;
        step(3);
        check_eq("sc_pnd_rise", pending_o[5], 1'b1);
        pin_i[5] = 1'b0;
        step(2);
        check_eq("sc_lvl_before", level_o[5], 1'b1);
        clr_i[5] = 1'b1;
        step(1);
        clr_i[5] = 1'b0;
        check_eq("sc_lvl_fell", level_o[5], 1'b0);
        check_eq("sc_set_wins", pending_o[5], 1'b1);
        clr_i[9] = 1'b1;
        step(1);
        clr_i[9] = 1'b0;
        check_eq("noop_clear", pending_o, 32'h0000_0020);

        // Debounce: a 6-cycle pulse spans at most 2 ticks and is rejected.
        deb_en_i  = 1'b1;
        rise_en_i = '0;
        fall_en_i = '0;
        seen_lvl  = 1'b0;
        pin_i[0]  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            seen_lvl |= level_o[0];
        end
        pin_i[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            seen_lvl |= level_o[0];
        end
        check_eq("deb_glitch", seen_lvl, 1'b0);

        // Held input: third tick after sync2 changes, i.e. edge 11..14 after the pad.
        pin_i[0] = 1'b1;
        first    = 0;
        for (int i = 1; i <= 24; i++) begin
            step(1);
            if (first == 0 && level_o[0] == 1'b1) first = i;
        end
        check_eq("deb_hold_win", (first >= 11 && first <= 14), 1'b1);
        check_eq("deb_hold_lvl", level_o[0], 1'b1);

        // Async reset clears everything at once, and discards debounce progress.
        check_eq("pre_rst_level", level_o, 32'h0000_0089);
        rst = 1'b1;
        #1;
        check_eq("arst_level", level_o, 32'h0);
        check_eq("arst_pending", pending_o, 32'h0);
        check_eq("arst_irq", irq_o, 1'b0);
        step(2);
        rst = 1'b0;
        step(9);
        rst = 1'b1;
        #1;
        check_eq("arst2_level", level_o, 32'h0);
        step(1);
        rst = 1'b0;
        step(11);
        check_eq("arst_restart_e11", level_o[0], 1'b0);
        step(1);
        check_eq("arst_restart_e12", level_o[0], 1'b1);

        // All bits toggle together with both edges enabled.
        deb_en_i  = 1'b0;
        rise_en_i = '1;
        fall_en_i = '1;
        step(3);
        check_eq("all_pnd_idle", pending_o, 32'h0);
        pin_i = ~pin_i;
        step(2);
        check_eq("all_pnd_edge2", pending_o, 32'h0);
        step(1);
        check_eq("all_pnd_set", pending_o, 32'hFFFF_FFFF);
        check_eq("all_irq_set", irq_o, 1'b1);
        clr_i = '1;
        step(1);
        clr_i = '0;
        check_eq("all_pnd_clr", pending_o, 32'h0);
        check_eq("all_irq_clr", irq_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
